// File: rtl/cavlc_fifo_arbiter_if.sv
// Write-side bus of the CAVLC output FIFO arbiter: both producer ports,
// flush/error control, and the FIFO write/flag signals.
interface cavlc_fifo_arbiter_if;
    logic        Req0;
    logic        Req1;
    logic [15:0] Data0;
    logic [15:0] Data1;
    logic        Last0;
    logic        Last1;
    logic        Ack0;
    logic        Ack1;
    logic        FlushReq;
    logic        FlushDone;
    logic        ErrClear;
    logic        FifoFull;
    logic        FifoOverflow;
    logic        FifoUnderflow;
    logic        FifoDataReady;
    logic [15:0] FifoDataIn;
    logic        FifoEnable;
    logic        Busy;
    logic [2:0]  ErrStatus;

    modport slave (
        input  Req0, Req1, Data0, Data1, Last0, Last1,
        input  FlushReq, ErrClear, FifoFull, FifoOverflow, FifoUnderflow,
        output Ack0, Ack1, FlushDone, FifoDataReady, FifoDataIn,
        output FifoEnable, Busy, ErrStatus
    );

    modport master (
        output Req0, Req1, Data0, Data1, Last0, Last1,
        output FlushReq, ErrClear, FifoFull, FifoOverflow, FifoUnderflow,
        input  Ack0, Ack1, FlushDone, FifoDataReady, FifoDataIn,
        input  FifoEnable, Busy, ErrStatus
    );
endinterface

// File: rtl/cavlc_fifo_arbiter.sv
// Packet-atomic round-robin arbiter sharing the CAVLC output FIFO write port
// between the header writer (port 0) and the coefficient packer (port 1).
module cavlc_fifo_arbiter #(
    parameter int MAX_PKT = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    cavlc_fifo_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LIMIT = 8'(MAX_PKT - 1);

    state_t      state;
    logic        lastServed;
    logic        flushPending;
    logic [7:0]  wordCnt;
    logic [2:0]  errStatus;

    logic        accept;
    logic        lastWord;
    logic [15:0] dataSel;
    logic        atLimit;
    logic        pktEnd;
    logic        tooLong;
    logic        enterFlush;

    // Word acceptance and data selection for the currently granted port
    always_comb begin
        accept   = 1'b0;
        lastWord = 1'b0;
        dataSel  = 16'h0000;
        case (state)
            GRANT0: begin
                accept   = bus.Req0 & ~bus.FifoFull;
                lastWord = bus.Last0;
                dataSel  = bus.Data0;
            end
            GRANT1: begin
                accept   = bus.Req1 & ~bus.FifoFull;
                lastWord = bus.Last1;
                dataSel  = bus.Data1;
            end
            default: begin
                accept   = 1'b0;
                lastWord = 1'b0;
                dataSel  = 16'h0000;
            end
        endcase
    end

    assign atLimit    = (wordCnt == CNT_LIMIT);
    assign pktEnd     = accept & (lastWord | atLimit);
    assign tooLong    = accept & ~lastWord & atLimit;
    assign enterFlush = (state == IDLE) & flushPending;

    assign bus.Ack0          = accept & (state == GRANT0);
    assign bus.Ack1          = accept & (state == GRANT1);
    assign bus.FifoDataReady = accept;
    assign bus.FifoDataIn    = accept ? dataSel : 16'h0000;
    assign bus.FifoEnable    = (state != FLUSH);
    assign bus.FlushDone     = (state == FLUSH);
    assign bus.Busy          = (state != IDLE) | flushPending;
    assign bus.ErrStatus     = errStatus;

    // Arbitration FSM: grants are only released at end of packet
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            lastServed <= 1'b1;
            wordCnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (flushPending) begin
                        state <= FLUSH;
                    end else if (bus.Req0 & ~bus.Req1) begin
                        state <= GRANT0;
                    end else if (~bus.Req0 & bus.Req1) begin
                        state <= GRANT1;
                    end else if (bus.Req0 & bus.Req1) begin
                        state <= lastServed ? GRANT0 : GRANT1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT0, GRANT1: begin
                    if (pktEnd) begin
                        state      <= IDLE;
                        lastServed <= (state == GRANT1);
                        wordCnt    <= 8'd0;
                    end else if (accept) begin
                        wordCnt <= wordCnt + 8'd1;
                    end else begin
                        wordCnt <= wordCnt;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flush request latch; a new pulse on the entry edge is not lost
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flushPending <= 1'b0;
        end else begin
            flushPending <= bus.FlushReq | (flushPending & ~enterFlush);
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            errStatus <= 3'b000;
        end else begin
            errStatus <= (bus.ErrClear ? 3'b000 : errStatus)
                       | {tooLong, bus.FifoUnderflow, bus.FifoOverflow};
        end
    end

endmodule
